// File: rtl/nvdla_apb_host.sv
// nvdla_apb_host: queued APB3 master for the NVDLA small-wrapper cfg port.
// Optional ACCESS-phase timeout is compiled in with `define NVDLA_APB_HOST_TIMEOUT_EN.
module nvdla_apb_host #(
   parameter int unsigned REQ_DEPTH   = 4,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic        core_clk,
   input  logic        rst,
   // request channel
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   // response channel
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_write,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   // APB3 master
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   output logic        busy
);

   localparam int unsigned AW = $clog2(REQ_DEPTH);
   localparam int unsigned PW = AW + 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSetup  = 2'd1;
   localparam logic [1:0] StAccess = 2'd2;

   if (REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("REQ_DEPTH must be a power of 2 and at least 2");
   end
   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be in 2..65535");
   end

   // FIFO entry layout: {write, addr, wdata}
   logic [64:0]   mem_q [REQ_DEPTH];
   logic [64:0]   mem_d [REQ_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          req_ready_q, req_ready_d;
   logic          fifo_empty;
   logic          push;
   logic          pop;

   logic [1:0]    state_q, state_d;
   logic          psel_q, psel_d;
   logic          penable_q, penable_d;
   logic          pwrite_q, pwrite_d;
   logic [31:0]   paddr_q, paddr_d;
   logic [31:0]   pwdata_q, pwdata_d;

   logic          rsp_load;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_write_q, rsp_write_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          timeout_hit;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign push       = req_valid && req_ready_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = {req_write, req_addr, req_wdata};
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // Registered ready reflects fullness after this cycle's push/pop.
      req_ready_d = !((wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
   end

`ifdef NVDLA_APB_HOST_TIMEOUT_EN
   localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYC - 1);

   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        rsp_err_q, rsp_err_d;

   assign timeout_hit = (state_q == StAccess) && !pready && (tmo_cnt_q == TimeoutLim);

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      rsp_err_d = rsp_err_q;
      if (state_q == StSetup) begin
         tmo_cnt_d = '0;
      end else if (state_q == StAccess && !pready && !timeout_hit) begin
         tmo_cnt_d = tmo_cnt_q + 16'd1;
      end
      if (rsp_load) begin
         rsp_err_d = timeout_hit;
      end
   end

   always_ff @(posedge core_clk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign timeout_hit = 1'b0;
   assign rsp_err     = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pop       = 1'b0;
      rsp_load  = 1'b0;
      case (state_q)
         StIdle: begin
            // Only start when the response slot will be free to take the result.
            if (!fifo_empty && (!rsp_valid_q || rsp_ready)) begin
               state_d                      = StSetup;
               psel_d                       = 1'b1;
               penable_d                    = 1'b0;
               {pwrite_d, paddr_d, pwdata_d} = mem_q[rd_ptr_q[AW-1:0]];
            end
         end
         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
         end
         StAccess: begin
            if (pready || timeout_hit) begin
               state_d   = StIdle;
               pop       = 1'b1;
               rsp_load  = 1'b1;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               pwrite_d  = 1'b0;
               paddr_d   = '0;
               pwdata_d  = '0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      if (rsp_load) begin
         rsp_valid_d = 1'b1;
         rsp_write_d = pwrite_q;
         rsp_rdata_d = (pwrite_q || timeout_hit) ? 32'd0 : prdata;
      end
   end

   // FIFO storage needs no reset; pointers define validity.
   always_ff @(posedge core_clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge core_clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         req_ready_q <= 1'b0;
         state_q     <= StIdle;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         req_ready_q <= req_ready_d;
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready = req_ready_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = !fifo_empty || (state_q != StIdle) || rsp_valid_q;

endmodule
